// File: rtl/fifo_async_write_ptr.sv
// Write-side pointer, full/almost-full/level flags and sticky overflow for the async FIFO.
// Publishes a registered Gray pointer toward the read-domain synchroniser.
module fifo_async_write_ptr #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_THRESH  = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  write_in,
    input  logic                  clr_ovf_in,
    input  logic [ADDR_WIDTH:0]   rptr_g_sync_in,
    output logic                  wen_out,
    output logic [ADDR_WIDTH-1:0] waddr_out,
    output logic [ADDR_WIDTH:0]   wptr_b_out,
    output logic [ADDR_WIDTH:0]   wptr_g_out,
    output logic                  full_out,
    output logic                  almost_full_out,
    output logic [ADDR_WIDTH:0]   level_out,
    output logic                  overflow_out
);

    localparam int unsigned PtrW = ADDR_WIDTH + 1;
    // Full when write Gray equals read Gray with its top two bits inverted.
    localparam logic [PtrW-1:0] FullMask = PtrW'(3) << (PtrW - 2);
    localparam logic [PtrW-1:0] AfThresh = PtrW'(AF_THRESH);

    function automatic logic [PtrW-1:0] gray2bin(input logic [PtrW-1:0] g);
        logic [PtrW-1:0] b;
        for (int i = 0; i < PtrW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [PtrW-1:0] wptr_b_q, wptr_b_d;
    logic [PtrW-1:0] wptr_g_q, wptr_g_d;
    logic [PtrW-1:0] level_q, level_d;
    logic [PtrW-1:0] rptr_b_sync;
    logic            full_q, full_d;
    logic            af_q, af_d;
    logic            ovf_q, ovf_d;
    logic            wen;

    always_comb begin
        wen         = write_in & ~full_q;
        rptr_b_sync = gray2bin(rptr_g_sync_in);
        wptr_b_d    = wptr_b_q + PtrW'(wen);
        wptr_g_d    = (wptr_b_d >> 1) ^ wptr_b_d;
        full_d      = (wptr_g_d == (rptr_g_sync_in ^ FullMask));
        level_d     = wptr_b_d - rptr_b_sync;
        af_d        = (level_d >= AfThresh);
        // Set has priority over clear.
        ovf_d       = (write_in & full_q) | (ovf_q & ~clr_ovf_in);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wptr_b_q <= '0;
            wptr_g_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wptr_b_q <= wptr_b_d;
            wptr_g_q <= wptr_g_d;
            level_q  <= level_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wen_out         = wen;
    assign waddr_out       = wptr_b_q[ADDR_WIDTH-1:0];
    assign wptr_b_out      = wptr_b_q;
    assign wptr_g_out      = wptr_g_q;
    assign full_out        = full_q;
    assign almost_full_out = af_q;
    assign level_out       = level_q;
    assign overflow_out    = ovf_q;

endmodule

// File: tb/tb_fifo_async_write_ptr.sv
// Directed self-checking bench for fifo_async_write_ptr (ADDR_WIDTH=3, AF_THRESH=6).
module tb_fifo_async_write_ptr;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       write_in;
    logic       clr_ovf_in;
    logic [3:0] rptr_g_sync_in;
    logic       wen_out;
    logic [2:0] waddr_out;
    logic [3:0] wptr_b_out;
    logic [3:0] wptr_g_out;
    logic       full_out;
    logic       almost_full_out;
    logic [3:0] level_out;
    logic       overflow_out;

    int n_checks = 0;
    int n_passed = 0;

    fifo_async_write_ptr #(
        .ADDR_WIDTH(3),
        .AF_THRESH (6)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .write_in       (write_in),
        .clr_ovf_in     (clr_ovf_in),
        .rptr_g_sync_in (rptr_g_sync_in),
        .wen_out        (wen_out),
        .waddr_out      (waddr_out),
        .wptr_b_out     (wptr_b_out),
        .wptr_g_out     (wptr_g_out),
        .full_out       (full_out),
        .almost_full_out(almost_full_out),
        .level_out      (level_out),
        .overflow_out   (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, " wptr_b"}, 32'(wptr_b_out), 0);
        check({tag, " wptr_g"}, 32'(wptr_g_out), 0);
        check({tag, " waddr"}, 32'(waddr_out), 0);
        check({tag, " full"}, 32'(full_out), 0);
        check({tag, " af"}, 32'(almost_full_out), 0);
        check({tag, " level"}, 32'(level_out), 0);
        check({tag, " ovf"}, 32'(overflow_out), 0);
    endtask

    initial begin
        logic [3:0] wbin;
        logic [3:0] rbin;
        logic [3:0] prev_g;

        rst_in         = 1'b1;
        write_in       = 1'b0;
        clr_ovf_in     = 1'b0;
        rptr_g_sync_in = 4'b0000;

        // Reset held two cycles
        step();
        step();
        check_reset_state("reset");
        rst_in   = 1'b0;
        write_in = 1'b1;
        #1 check("reset wen=1", 32'(wen_out), 1);
        write_in = 1'b0;
        #1 check("reset wen=0", 32'(wen_out), 0);

        // Fill: 8 accepted writes, level and almost-full tracked per write
        write_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("fill waddr", 32'(waddr_out), 32'(i - 1));
            step();
            check("fill wptr_b", 32'(wptr_b_out), 32'(i));
            check("fill level", 32'(level_out), 32'(i));
            check("fill af", 32'(almost_full_out), (i >= 6) ? 1 : 0);
            check("fill full", 32'(full_out), (i == 8) ? 1 : 0);
        end
        check("fill wptr_g", 32'(wptr_g_out), 32'h0000_000c);
        // 9th write rejected
        check("ovf wen", 32'(wen_out), 0);
        step();
        check("ovf wptr_b held", 32'(wptr_b_out), 8);
        check("ovf set", 32'(overflow_out), 1);

        // Set and clear in the same cycle: set wins
        clr_ovf_in = 1'b1;
        step();
        check("ovf set beats clr", 32'(overflow_out), 1);
        write_in = 1'b0;
        step();
        check("ovf cleared", 32'(overflow_out), 0);
        clr_ovf_in = 1'b0;

        // Release: read pointer advances while a write is attempted on full
        rptr_g_sync_in = 4'b0001;
        write_in       = 1'b1;
        #1 check("release wen", 32'(wen_out), 0);
        step();
        check("release wptr_b held", 32'(wptr_b_out), 8);
        check("release full drop", 32'(full_out), 0);
        check("release level", 32'(level_out), 7);
        check("release waddr", 32'(waddr_out), 0);
        check("release wen2", 32'(wen_out), 1);
        step();
        check("release wptr_b", 32'(wptr_b_out), 9);
        check("release wptr_g", 32'(wptr_g_out), 32'h0000_000d);
        check("release refull", 32'(full_out), 1);
        check("release level8", 32'(level_out), 8);

        // Drain to level 5 with overflow still set (from the rejected release write)
        write_in = 1'b0;
        rptr_g_sync_in = 4'b0011;
        step();
        rptr_g_sync_in = 4'b0010;
        step();
        rptr_g_sync_in = 4'b0110;
        step();
        check("drain level5", 32'(level_out), 5);
        check("drain af off", 32'(almost_full_out), 0);
        check("drain ovf", 32'(overflow_out), 1);
        check("drain full", 32'(full_out), 0);

        // Mid-operation reset
        rst_in   = 1'b1;
        write_in = 1'b1;
        step();
        check_reset_state("midreset");
        write_in       = 1'b0;
        rptr_g_sync_in = 4'b0000;
        step();
        rst_in = 1'b0;

        // Wrap: write then read-advance, 20 writes, level stays <= 1
        wbin   = 4'd0;
        rbin   = 4'd0;
        prev_g = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            write_in = 1'b1;
            step();
            wbin = wbin + 4'd1;
            check("wrap wptr_g", 32'(wptr_g_out), 32'(to_gray(wbin)));
            check("wrap one-bit", 32'($countones(wptr_g_out ^ prev_g)), 1);
            check("wrap full", 32'(full_out), 0);
            prev_g         = wptr_g_out;
            write_in       = 1'b0;
            rbin           = rbin + 4'd1;
            rptr_g_sync_in = to_gray(rbin);
            step();
            check("wrap level", 32'(level_out), 0);
        end
        check("wrap wptr_b", 32'(wptr_b_out), 4);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
